regfile_decoded: RTL
====================

REGFILE_DECODED -- requirements
Module: regfile_decoded

Interface
REQ-001 The block SHALL have parameter AW, default 3, meaning address width; DEPTH = 2^AW registers.
REQ-002 The block SHALL have parameter DW, default 8, meaning data width of each register.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Clock  input  1  rising-edge clock.
REQ-005 Resetn  input  1  asynchronous active-low reset.
REQ-006 WE  input  1  write request, sampled on the rising edge.
REQ-007 WADDR  input  AW  write address.
REQ-008 WDATA  input  DW  write data.
REQ-009 RADDR_A, RADDR_B  input  AW each  read addresses.
REQ-010 RDATA_A, RDATA_B  output  DW each  read data.
REQ-011 CLR  input  1  start a sequential clear of all registers.
REQ-012 BUSY  output  1  high while a clear sequence runs.
REQ-013 WEN  output  DEPTH  registered one-hot write-enable vector; bit k drives register k.
REQ-014 WERR  output  1  one-cycle pulse marking a dropped write.

Function
REQ-015 The write path SHALL decode WADDR into a one-hot DEPTH-bit vector, gated by WE, acting as a generalised AW-to-DEPTH enabled decoder.
REQ-016 In IDLE with WE=1 and CLR=0, register[WADDR] SHALL take WDATA at that rising edge; all other registers hold.
REQ-017 WEN SHALL show the one-hot vector applied at the most recent edge: bit WADDR is high for one cycle after an accepted write, otherwise all zeros.
REQ-018 Reads SHALL be combinational: RDATA_x = register[RADDR_x] with no bypass, so a read of the address being written shows the old value until the edge and the new value after it.
REQ-019 Both read ports SHALL be independent and MAY address the same register.
REQ-020 The FSM SHALL have two states, IDLE and CLEAR.
REQ-021 IDLE -> CLEAR on a rising edge with CLR=1; the clear counter loads 0 and BUSY rises on the same edge.
REQ-022 In CLEAR, each rising edge SHALL write zero to register[counter], set WEN to one-hot(counter), and increment the counter.
REQ-023 The clear SHALL take exactly DEPTH cycles; on the edge that writes register DEPTH-1, the FSM returns to IDLE and BUSY falls.
REQ-024 The counter SHALL be AW bits wide and SHALL NOT wrap; its terminal value is DEPTH-1.
REQ-025 Any WE=1 edge while in CLEAR SHALL be dropped, and WERR SHALL pulse high for one cycle.
REQ-026 WE=1 and CLR=1 on the same edge in IDLE: CLR wins, the write is dropped, and WERR pulses.
REQ-027 CLR=1 while in CLEAR SHALL be ignored; it neither restarts nor extends the sequence.
REQ-028 WERR SHALL be 0 on every edge except those defined in REQ-025 and REQ-026.

Reset
REQ-029 While Resetn=0, regardless of Clock, the block SHALL drive: all registers 0, state IDLE, counter 0, BUSY=0, WEN=0, WERR=0.
REQ-030 Reset asserted mid-clear SHALL abort the sequence immediately, leaving all registers 0 and the FSM in IDLE.
REQ-031 After Resetn rises, the first edge with WE=1 SHALL be accepted normally.

Verification
REQ-032 Reset, then write 0x5A to address 3 and read A=3, B=0 -> RDATA_A=0x5A, RDATA_B=0x00; WEN=8'b0000_1000 for one cycle.
REQ-033 Write 0xFF to address 7, with RADDR_A=7 in the same cycle -> old value before the edge, 0xFF after it.
REQ-034 Fill all 8 registers, then pulse CLR -> BUSY high for exactly 8 cycles; WEN walks 0x01..0x80; all registers read 0x00.
REQ-035 WE=1 to address 2 at the 3rd cycle of a clear -> WERR pulses once; register 2 ends 0x00.
REQ-036 WE=1 and CLR=1 on the same edge -> write dropped, WERR=1, clear starts.
REQ-037 Assert Resetn=0 at the 4th clear cycle -> BUSY=0 and WEN=0 immediately; all registers 0; a normal write succeeds after release.

Source files
------------

// File: rtl/regfile_decoded.sv
// Two-read, one-write register file with a registered one-hot write decoder
// and a sequential clear engine that walks every register to zero.
module regfile_decoded #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  WE,
    input  logic [AW-1:0]         WADDR,
    input  logic [DW-1:0]         WDATA,
    input  logic [AW-1:0]         RADDR_A,
    input  logic [AW-1:0]         RADDR_B,
    output logic [DW-1:0]         RDATA_A,
    output logic [DW-1:0]         RDATA_B,
    input  logic                  CLR,
    output logic                  BUSY,
    output logic [(1<<AW)-1:0]    WEN,
    output logic                  WERR
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [DEPTH-1:0]    wen_q, wen_d;
    logic                werr_q, werr_d;
    logic [DW-1:0]       mem_q [DEPTH];
    logic [DW-1:0]       mem_d [DEPTH];

    function automatic logic [DEPTH-1:0] decode(
        input logic          en,
        input logic [AW-1:0] addr
    );
        logic [DEPTH-1:0] v;
        v = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v[k] = en && (addr == AW'(k));
        end
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        wen_d   = '0;
        werr_d  = 1'b0;
        mem_d   = mem_q;
        unique case (state_q)
            IDLE: begin
                if (CLR) begin
                    // Clear wins over a coincident write
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    werr_d  = WE;
                end else begin
                    wen_d = decode(WE, WADDR);
                    if (WE) begin
                        mem_d[WADDR] = WDATA;
                    end
                end
            end
            CLEAR: begin
                mem_d[cnt_q] = '0;
                wen_d        = decode(1'b1, cnt_q);
                werr_d       = WE;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            wen_q   <= '0;
            werr_q  <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            wen_q   <= wen_d;
            werr_q  <= werr_d;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    assign RDATA_A = mem_q[RADDR_A];
    assign RDATA_B = mem_q[RADDR_B];
    assign BUSY    = busy_q;
    assign WEN     = wen_q;
    assign WERR    = werr_q;

endmodule
